// File: rtl/out_port_seg_display.sv
// CPU out-port to six-digit seven-segment display: serial double-dabble
// binary-to-BCD conversion with a one-deep pending write buffer.
module out_port_seg_display #(
  parameter int BLANK_LEADING = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] data_in,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic        busy,
  output logic        overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_UPDATE
  } state_t;

  localparam logic [6:0]  SEG_BLANK  = 7'b1111111;
  localparam logic [6:0]  SEG_DASH   = 7'b0111111;
  localparam logic [6:0]  SEG_ZERO   = 7'b1000000;
  localparam logic [6:0]  RST_UPPER  = (BLANK_LEADING != 0) ? SEG_BLANK : SEG_ZERO;
  localparam logic [31:0] MAX_SHOWN  = 32'd999999;
  localparam logic [4:0]  LAST_ITER  = 5'd19;

  state_t       r_state;
  state_t       w_next;

  logic [19:0]  r_bin;
  logic [23:0]  r_bcd;
  logic [4:0]   r_cnt;
  logic         r_ovf;
  logic         r_pend;
  logic [31:0]  r_pend_val;

  logic         w_start;
  logic [31:0]  w_start_val;
  logic         w_pend_wr;
  logic [23:0]  w_bcd_adj;
  logic [5:0]   w_blank;
  logic [6:0]   w_hex [6];

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (load) w_next = S_CONV;
      S_CONV:   if (r_cnt == LAST_ITER) w_next = S_UPDATE;
      S_UPDATE: w_next = (r_pend || load) ? S_CONV : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (r_state != S_IDLE);
  end

  // A new conversion starts from IDLE on load, or back-to-back out of UPDATE.
  // Out of UPDATE the buffered value takes precedence; a load landing on that
  // same edge with nothing buffered is converted directly instead of buffered.
  always_comb begin
    w_start     = 1'b0;
    w_start_val = data_in;
    w_pend_wr   = 1'b0;
    case (r_state)
      S_IDLE: w_start = load;
      S_CONV: w_pend_wr = load;
      S_UPDATE: begin
        w_start   = r_pend || load;
        w_pend_wr = r_pend && load;
        if (r_pend) w_start_val = r_pend_val;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int unsigned i = 0; i < 6; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // Leading-zero blanking walks down from the top digit; hex0 is never blanked.
  always_comb begin
    logic w_allz;
    w_allz  = 1'b1;
    w_blank = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      w_allz = w_allz && (r_bcd[4*(5-i) +: 4] == 4'd0);
      w_blank[5-i] = w_allz && (BLANK_LEADING != 0);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 6; i++) begin
      if (r_ovf)           w_hex[i] = SEG_DASH;
      else if (w_blank[i]) w_hex[i] = SEG_BLANK;
      else                 w_hex[i] = seg7(r_bcd[4*i +: 4]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_pend     <= 1'b0;
      r_pend_val <= '0;
      overflow   <= 1'b0;
      hex0       <= SEG_ZERO;
      hex1       <= RST_UPPER;
      hex2       <= RST_UPPER;
      hex3       <= RST_UPPER;
      hex4       <= RST_UPPER;
      hex5       <= RST_UPPER;
    end else begin
      if (w_start) begin
        r_ovf <= (w_start_val > MAX_SHOWN);
        r_bin <= w_start_val[19:0];
        r_bcd <= '0;
        r_cnt <= '0;
      end else if (r_state == S_CONV) begin
        {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
        r_cnt          <= r_cnt + 5'd1;
      end

      if (w_pend_wr) begin
        r_pend     <= 1'b1;
        r_pend_val <= data_in;
      end else if (r_state == S_UPDATE) begin
        r_pend <= 1'b0;
      end

      if (r_state == S_UPDATE) begin
        overflow <= r_ovf;
        hex0     <= w_hex[0];
        hex1     <= w_hex[1];
        hex2     <= w_hex[2];
        hex3     <= w_hex[3];
        hex4     <= w_hex[4];
        hex5     <= w_hex[5];
      end
    end
  end

endmodule

// File: tb/tb_out_port_seg_display.sv
// Bench for out_port_seg_display: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a transaction model.
module tb_out_port_seg_display;

  logic        clock;
  logic        reset;
  logic        load;
  logic [31:0] data_in;

  logic [6:0]  hb0, hb1, hb2, hb3, hb4, hb5;
  logic        busy_b, ovf_b;
  logic [6:0]  hf0, hf1, hf2, hf3, hf4, hf5;
  logic        busy_f, ovf_f;

  out_port_seg_display #(.BLANK_LEADING(1)) u_dut_blank (
    .clock(clock), .reset(reset), .load(load), .data_in(data_in),
    .hex0(hb0), .hex1(hb1), .hex2(hb2), .hex3(hb3), .hex4(hb4), .hex5(hb5),
    .busy(busy_b), .overflow(ovf_b)
  );

  out_port_seg_display #(.BLANK_LEADING(0)) u_dut_full (
    .clock(clock), .reset(reset), .load(load), .data_in(data_in),
    .hex0(hf0), .hex1(hf1), .hex2(hf2), .hex3(hf3), .hex4(hf4), .hex5(hf5),
    .busy(busy_f), .overflow(ovf_f)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] DS = 7'b0111111;

  logic [6:0] SEG [10];

  int n_vec = 0;
  int n_err = 0;

  // Transaction-level model: cycles left until the display update, value in
  // flight, one buffered value, and the value currently on the display.
  int          m_cnt  = 0;
  int unsigned m_cur  = 0;
  int unsigned m_pend = 0;
  bit          m_pv   = 0;
  int unsigned m_disp = 0;

  typedef struct {
    logic [31:0] din;
    logic [41:0] hx;   // {hex5, ..., hex0}, BLANK_LEADING=1 view
    logic        ovf;
  } vec_t;

  vec_t tbl [9];

  function automatic logic [41:0] exp_disp(input int unsigned v, input bit blank);
    logic [41:0] r;
    longint unsigned p;
    r = '0;
    p = 1;
    if (v > 999999) return {6{DS}};
    for (int k = 0; k < 6; k++) begin
      if (blank && k != 0 && longint'(v) < p) r[7*k +: 7] = BL;
      else r[7*k +: 7] = SEG[(longint'(v) / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [41:0] act, input logic [41:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit ld, input logic [31:0] d);
    if (rst) begin
      m_cnt = 0; m_pv = 0; m_disp = 0;
    end else if (m_cnt == 0) begin
      if (ld) begin m_cur = d; m_cnt = 21; end
    end else begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_disp = m_cur;
        if (m_pv) begin
          m_cur = m_pend; m_cnt = 21; m_pv = ld;
          if (ld) m_pend = d;
        end else if (ld) begin
          m_cur = d; m_cnt = 21;
        end
      end else if (ld) begin
        m_pv = 1; m_pend = d;
      end
    end
  endtask

  task automatic check_model();
    chk("busy_b", 42'(busy_b), 42'(m_cnt != 0));
    chk("busy_f", 42'(busy_f), 42'(m_cnt != 0));
    chk("ovf_b", 42'(ovf_b), 42'(m_disp > 999999));
    chk("ovf_f", 42'(ovf_f), 42'(m_disp > 999999));
    chk("hex_b", {hb5, hb4, hb3, hb2, hb1, hb0}, exp_disp(m_disp, 1'b1));
    chk("hex_f", {hf5, hf4, hf3, hf2, hf1, hf0}, exp_disp(m_disp, 1'b0));
  endtask

  task automatic step(input bit rst, input bit ld, input logic [31:0] d);
    reset = rst; load = ld; data_in = d;
    @(posedge clock);
    model_edge(rst, ld, d);
    #1;
    check_model();
    reset = 1'b0; load = 1'b0;
  endtask

  task automatic run_idle(output int nbusy);
    nbusy = 0;
    for (int g = 0; g < 60; g++) begin
      if (!busy_b) break;
      nbusy++;
      step(1'b0, 1'b0, '0);
    end
  endtask

  initial begin
    int  nb;
    bit  seen10;
    int  sel;
    logic [31:0] rd;

    SEG = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    tbl[0] = '{32'd123456, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010}, 1'b0};
    tbl[1] = '{32'd7,       {BL, BL, BL, BL, BL, 7'b1111000}, 1'b0};
    tbl[2] = '{32'd1000000, {6{DS}}, 1'b1};
    tbl[3] = '{32'hFFFFFFFF, {6{DS}}, 1'b1};
    tbl[4] = '{32'd999999,  {6{7'b0010000}}, 1'b0};
    tbl[5] = '{32'd0,       {BL, BL, BL, BL, BL, 7'b1000000}, 1'b0};
    tbl[6] = '{32'd100500,  {7'b1111001, 7'b1000000, 7'b1000000, 7'b0010010, 7'b1000000, 7'b1000000}, 1'b0};
    tbl[7] = '{32'h00100000, {6{DS}}, 1'b1};
    tbl[8] = '{32'd42,      {BL, BL, BL, BL, 7'b0011001, 7'b0100100}, 1'b0};

    reset = 1'b0; load = 1'b0; data_in = '0;
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    chk("rst_hex_b", {hb5, hb4, hb3, hb2, hb1, hb0}, {BL, BL, BL, BL, BL, 7'b1000000});
    chk("rst_hex_f", {hf5, hf4, hf3, hf2, hf1, hf0}, {6{7'b1000000}});
    chk("rst_busy", 42'(busy_b), 42'd0);
    chk("rst_ovf", 42'(ovf_b), 42'd0);

    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b1, tbl[i].din);
      run_idle(nb);
      chk("busy_len", 42'(nb), 42'd21);
      chk("tbl_hex", {hb5, hb4, hb3, hb2, hb1, hb0}, tbl[i].hx);
      chk("tbl_ovf", 42'(ovf_b), 42'(tbl[i].ovf));
    end

    step(1'b0, 1'b1, 32'd7);
    run_idle(nb);
    chk("full_hex7", {hf5, hf4, hf3, hf2, hf1, hf0}, {{5{7'b1000000}}, 7'b1111000});

    // 42, then 10 and 99 while busy: only 42 and 99 may ever be shown.
    seen10 = 0;
    step(1'b0, 1'b1, 32'd42);
    for (int k = 1; k <= 42; k++) begin
      step(1'b0, (k == 5 || k == 10), (k == 5) ? 32'd10 : 32'd99);
      if ({hb1, hb0} == {7'b1111001, 7'b1000000}) seen10 = 1;
      if (k == 21) begin
        chk("pend_42", {hb5, hb4, hb3, hb2, hb1, hb0}, {BL, BL, BL, BL, 7'b0011001, 7'b0100100});
        chk("pend_busy", 42'(busy_b), 42'd1);
      end
    end
    chk("pend_99", {hb5, hb4, hb3, hb2, hb1, hb0}, {BL, BL, BL, BL, 7'b0010000, 7'b0010000});
    chk("pend_done", 42'(busy_b), 42'd0);
    chk("never_10", 42'(seen10), 42'd0);

    // Reset lands on E10 of a conversion of 555555.
    step(1'b0, 1'b1, 32'd555555);
    for (int k = 1; k <= 9; k++) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    chk("midrst_busy", 42'(busy_b), 42'd0);
    chk("midrst_hex", {hb5, hb4, hb3, hb2, hb1, hb0}, {BL, BL, BL, BL, BL, 7'b1000000});
    for (int k = 0; k < 30; k++) step(1'b0, 1'b0, '0);
    chk("midrst_hold", {hb5, hb4, hb3, hb2, hb1, hb0}, {BL, BL, BL, BL, BL, 7'b1000000});

    step(1'b1, 1'b1, 32'd123456);
    chk("rst_prio", 42'(busy_b), 42'd0);

    // Randomized traffic, alternating sparse and dense write bursts.
    for (int c = 0; c < 3000; c++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3, 4, 5: rd = $urandom_range(0, 999999);
        6:                rd = ($urandom_range(0, 1) != 0) ? 32'd999999 : 32'd1000000;
        7:                rd = $urandom;
        8:                rd = $urandom_range(0, 99);
        default:          rd = 32'h000F0000 | $urandom_range(0, 65535);
      endcase
      step($urandom_range(0, 399) == 0,
           ((c / 500) % 2 == 0) ? ($urandom_range(0, 30) == 0) : ($urandom_range(0, 3) == 0),
           rd);
    end
    for (int k = 0; k < 50; k++) step(1'b0, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/out_port_seg_display.md
OUT_PORT_SEG_DISPLAY -- requirements
Module: out_port_seg_display

Interface
REQ-001 SHALL have parameter BLANK_LEADING, default 1; 1 = blank leading zero digits, 0 = show all six digits.
REQ-002 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on rising clock.
REQ-004 SHALL have port load, input, 1 bit: write strobe from the CPU I/O out-port decode; one cycle per write.
REQ-005 SHALL have port data_in, input, 32 bits: out-port value written by the CPU, sampled when load=1.
REQ-006 SHALL have ports hex0..hex5, output, 7 bits each: active-low segments {g,f,e,d,c,b,a}; hex0 = least significant decimal digit.
REQ-007 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-008 SHALL have port overflow, output, 1 bit: high while the displayed value exceeds 999999.

Function
REQ-009 SHALL use a 3-state FSM: IDLE, CONV, UPDATE.
REQ-010 SHALL, in IDLE with load=1 at edge E0, capture data_in, set the overflow flag if data_in > 999999, load data_in[19:0] into a shift register, clear a 24-bit BCD accumulator, and enter CONV.
REQ-011 SHALL, in CONV on edges E1..E20, perform one double-dabble iteration per edge: first add 3 to every BCD nibble >= 5, then shift {BCD, binary} left by 1.
REQ-012 SHALL count exactly 20 iterations with a 5-bit counter, then enter UPDATE after E20.
REQ-013 SHALL, in UPDATE at E21, register all hex outputs and the overflow output, then return to IDLE.
REQ-014 SHALL encode digits 0-9 as 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
REQ-015 SHALL, when the overflow flag is set, drive all six hex outputs to dash 0111111 and set overflow=1; otherwise set overflow=0.
REQ-016 SHALL, when BLANK_LEADING=1 and overflow=0, drive each leading zero digit above hex0 to 1111111; hex0 is always shown.
REQ-017 SHALL drive busy=1 from after E0 through E21 inclusive, and busy=0 in IDLE.
REQ-018 SHALL hold hex outputs and overflow at their previous values from E0 until E21; outputs never show partial results.
REQ-019 SHALL keep a one-deep pending buffer: load=1 while in CONV or UPDATE stores data_in and sets pending; a later load overwrites the stored value (last write wins).
REQ-020 SHALL, at E21 with pending set, update the outputs, clear pending, load the pending value as a new E0, and stay busy=1; the conversion is never aborted by load.
REQ-021 SHALL, when load=1 coincides with E21, treat it as the pending value for the immediately following conversion.
REQ-022 SHALL treat data_in values 0 and 999999 as in range; 1000000 and any value with data_in[31:20] != 0 are overflow.

Reset
REQ-023 SHALL, on reset=1 at any edge including mid-CONV, enter IDLE, clear pending, the counter, and the accumulators, and set busy=0 and overflow=0.
REQ-024 SHALL, on reset, set hex0=1000000 and hex1..hex5=1111111 when BLANK_LEADING=1, or all hex outputs to 1000000 when BLANK_LEADING=0.
REQ-025 SHALL give reset priority over load in the same cycle.

Verification
REQ-026 Bench SHALL check: load data_in=123456 in IDLE -> busy high for 21 cycles; after E21 hex5..hex0 = 1..6 patterns, overflow=0.
REQ-027 Bench SHALL check: load 7 with BLANK_LEADING=1 -> hex0=1111000, hex1..hex5=1111111; with BLANK_LEADING=0 -> hex1..hex5=1000000.
REQ-028 Bench SHALL check: load 1000000, then load 0xFFFFFFFF -> all hex=0111111 and overflow=1; then load 999999 -> all digits 9 and overflow=0.
REQ-029 Bench SHALL check: load 42 then load 10 and 99 during busy -> display shows 42 at E21, busy stays high, 99 shows at E21+21, and 10 never appears.
REQ-030 Bench SHALL check: reset asserted at cycle E10 of a conversion of 555555 -> next cycle busy=0, hex0=1000000, others blank, and no later update occurs.
